ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single external-memory AHB-Lite slave path between
//  N bus masters (ReadSystem, WriteSystem, Other traffic generator). Watches each
//  master's HTRANS and slave_done, and drives a per-master HREADY so exactly one master
//  owns the bus at a time. Replaces the ad-hoc switch logic between masters and memory.
// PARAMETERS
//  N_MASTERS         3    number of requesting masters (2..4)
//  MAX_GRANT_CYCLES  64   grant watchdog limit in HCLK cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  HCLK          in   1            system clock; all logic on rising edge
//  HRESETn       in   1            synchronous, active-low reset
//  i_HTRANS      in   2*N_MASTERS  per-master HTRANS; master k at [2k+1:2k]
//  i_slave_done  in   N_MASTERS    per-master end-of-burst pulse from its slave side
//  o_HREADY      out  N_MASTERS    per-master bus-ready; one-hot or zero
//  o_grant_id    out  2            index of current owner (valid when o_bus_busy=1)
//  o_bus_busy    out  1            1 while any master holds the grant
//  o_timeout     out  1            1-cycle pulse on forced release (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  - Clocking: one clock HCLK; reset synchronous, active-low on HRESETn.
//  - Reset: o_HREADY=0, o_grant_id=0, o_bus_busy=0, o_timeout=0, state=IDLE,
//    rr_ptr=0 (master 0 highest priority first), grant counter=0.
//  - Request: master k requests iff i_HTRANS[k]==NONSEQ (2'b10). IDLE/BUSY/SEQ
//    from a non-owner is not a request.
//  - FSM states: IDLE -> GRANT -> RELEASE -> IDLE.
//    IDLE: if any request, select winner by round robin searching from rr_ptr
//      upward with wrap; register winner; next state GRANT. No request: stay.
//    GRANT: o_HREADY[winner]=1, all others 0; o_bus_busy=1. Stays until
//      i_slave_done[winner]=1 -> RELEASE. Owner dropping NONSEQ/HTRANS=IDLE does
//      NOT release; only slave_done (or timeout) releases.
//    RELEASE: 1 dead cycle, all o_HREADY=0, o_bus_busy=0; rr_ptr=(winner+1)
//      mod N_MASTERS; next IDLE.
//  - Latency: request sampled at edge t -> o_HREADY high from edge t+1. Done at
//    edge t -> o_HREADY low from edge t+1. Minimum owner-to-owner gap: 2 cycles
//    (RELEASE + IDLE arbitration).
//  - Simultaneous requests: resolved purely by rr_ptr; a continuously requesting
//    master waits at most N_MASTERS-1 grants.
//  - i_slave_done from a non-owner: ignored, no state change.
//  - slave_done in the same cycle the grant is entered: not possible (done is
//    only evaluated in GRANT); done held high across RELEASE/IDLE is ignored.
//  - rr_ptr wrap: owner N_MASTERS-1 -> rr_ptr=0.
//  - Reset mid-grant: HREADY drops at the reset edge; no pulse on o_timeout.
//  - o_HREADY is registered, never combinational from inputs; one-hot0 always.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: grant counter counts cycles in GRANT (cleared on entry);
//    when it reaches MAX_GRANT_CYCLES-1 without done, force RELEASE next edge, pulse
//    o_timeout for 1 cycle, advance rr_ptr as for a normal release.
//  ARB_TIMEOUT_EN undefined: no counter; o_timeout tied 0; grant held indefinitely
//    until slave_done.
// TESTING
//  1 Reset: HRESETn=0 for 3 cycles with all masters NONSEQ -> o_HREADY=3'b000,
//    o_bus_busy=0; release reset -> next edge o_HREADY=3'b001, o_grant_id=0.
//  2 Round robin: masters 0,1,2 all NONSEQ, each pulses done 4 cycles after grant ->
//    grant order 0,1,2,0; 2 dead cycles between owners; never two HREADY bits high.
//  3 Wrap/fairness: only masters 2 and 0 request, rr_ptr=2 -> grant 2, then 0, then 2.
//  4 Stray done: master 1 owns, pulse i_slave_done[0] and [2] -> grant to 1 unchanged;
//    owner drops HTRANS to IDLE -> HREADY[1] stays 1 until i_slave_done[1].
//  5 Timeout (ARB_TIMEOUT_EN, MAX_GRANT_CYCLES=8): master 0 never done -> HREADY[0]
//    high exactly 8 cycles, o_timeout 1-cycle pulse, master 1 granted 2 cycles later;
//    without macro HREADY[0] stays high 100+ cycles, o_timeout=0.
//  6 Reset mid-grant: assert HRESETn=0 while master 2 owns -> all HREADY 0 next edge,
//    after release master 0 wins first.

Source files
------------

// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side bundle between the AHB masters and the round-robin arbiter.
// master: traffic generators; slave: the arbiter itself.
interface ahb_bus_arbiter_if #(
  parameter int N_MASTERS = 3
);
  logic [2*N_MASTERS-1:0] i_HTRANS;
  logic [N_MASTERS-1:0]   i_slave_done;
  logic [N_MASTERS-1:0]   o_HREADY;
  logic [1:0]             o_grant_id;
  logic                   o_bus_busy;
  logic                   o_timeout;

  modport master (
    output i_HTRANS,
    output i_slave_done,
    input  o_HREADY,
    input  o_grant_id,
    input  o_bus_busy,
    input  o_timeout
  );

  modport slave (
    input  i_HTRANS,
    input  i_slave_done,
    output o_HREADY,
    output o_grant_id,
    output o_bus_busy,
    output o_timeout
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin owner selection for the shared external-memory AHB-Lite path.
// Define ARB_TIMEOUT_EN to add the grant watchdog (MAX_GRANT_CYCLES).
module ahb_bus_arbiter #(
  parameter int N_MASTERS        = 3,
  parameter int MAX_GRANT_CYCLES = 64
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);

  if (N_MASTERS < 2 || N_MASTERS > 4 ||
      MAX_GRANT_CYCLES < 2) begin : g_bad_cfg
    $error("ahb_bus_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           win_q, win_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [N_MASTERS-1:0] rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic [N_MASTERS-1:0] req;
  logic [3:0]           req4;
  logic [1:0]           pick;
  logic                 found;
  logic [2:0]           sum;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_GRANT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_req
    assign req[k] = (bus.i_HTRANS[2*k+1 -: 2] == 2'b10);
  end

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    req4  = '0;
    req4[N_MASTERS-1:0] = req;
    pick  = ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      sum = {1'b0, ptr_q} + 3'(i);
      if (sum >= 3'(N_MASTERS)) sum = sum - 3'(N_MASTERS);
      if (!found && req4[sum[1:0]]) begin
        found = 1'b1;
        pick  = sum[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d       = pick;
          rdy_d       = '0;
          rdy_d[pick] = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_GRANT: begin
        if (bus.i_slave_done[win_q]) begin
          rdy_d   = '0;
          busy_d  = 1'b0;
          state_d = S_RELEASE;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(MAX_GRANT_CYCLES-1)) begin
          rdy_d   = '0;
          busy_d  = 1'b0;
          to_d    = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_RELEASE: begin
        ptr_d   = (win_q == 2'(N_MASTERS-1)) ?
                  2'd0 : win_q + 2'd1;
        state_d = S_IDLE;
      end
      default: begin
        rdy_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      rdy_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.o_timeout = to_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_HREADY   = rdy_q;
  assign bus.o_grant_id = win_q;
  assign bus.o_bus_busy = busy_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, round robin, wrap,
// stray done, watchdog (or its absence) and reset mid-grant.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   total = 0;
  int   bad   = 0;

  ahb_bus_arbiter_if #(.N_MASTERS(3)) bus ();

  ahb_bus_arbiter #(
    .N_MASTERS       (3),
    .MAX_GRANT_CYCLES(8)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_trans(input logic [1:0] t2,
                           input logic [1:0] t1,
                           input logic [1:0] t0);
    bus.i_HTRANS = {t2, t1, t0};
  endtask

  // entered just after the grant edge; leaves the arbiter in IDLE
  task automatic serve(input int id, input int hold);
    logic [2:0] oh;
    oh = 3'b001 << id;
    chk("own_rdy", bus.o_HREADY, oh);
    chk("own_id", bus.o_grant_id, id);
    chk("own_busy", bus.o_bus_busy, 1);
    repeat (hold - 1) begin
      step();
      chk("hold_rdy", bus.o_HREADY, oh);
      chk("onehot0", $onehot0(bus.o_HREADY), 1);
    end
    bus.i_slave_done = oh;
    step();
    bus.i_slave_done = '0;
    chk("rel_rdy", bus.o_HREADY, 0);
    chk("rel_busy", bus.o_bus_busy, 0);
    step();
    chk("idle_rdy", bus.o_HREADY, 0);
    chk("idle_busy", bus.o_bus_busy, 0);
  endtask

  initial begin
    HRESETn          = 1'b0;
    bus.i_slave_done = '0;
    set_trans(NS, NS, NS);

    // reset with all masters requesting
    repeat (3) step();
    chk("rst_rdy", bus.o_HREADY, 0);
    chk("rst_busy", bus.o_bus_busy, 0);
    chk("rst_id", bus.o_grant_id, 0);
    chk("rst_to", bus.o_timeout, 0);
    HRESETn = 1'b1;
    step();

    // round robin 0,1,2,0
    serve(0, 4);
    step();
    serve(1, 4);
    step();
    serve(2, 4);
    step();
    serve(0, 4);

    // only master 1 -> rr_ptr becomes 2
    set_trans(ID, NS, ID);
    step();
    serve(1, 2);

    // wrap: masters 2 and 0 only
    set_trans(NS, ID, NS);
    step();
    serve(2, 3);
    step();
    serve(0, 3);
    step();
    serve(2, 3);

    // stray done from non-owners, owner goes IDLE
    set_trans(ID, NS, ID);
    step();
    chk("stray_own", bus.o_HREADY, 3'b010);
    bus.i_slave_done = 3'b101;
    repeat (2) begin
      step();
      chk("stray_rdy", bus.o_HREADY, 3'b010);
      chk("stray_id", bus.o_grant_id, 1);
    end
    bus.i_slave_done = '0;
    set_trans(ID, ID, ID);
    repeat (3) begin
      step();
      chk("idle_keep", bus.o_HREADY, 3'b010);
    end
    serve(1, 1);

    // rr_ptr=2, masters 0 and 1 request -> master 0 wins
    set_trans(ID, NS, NS);
    step();
    chk("wd_own", bus.o_HREADY, 3'b001);
`ifdef ARB_TIMEOUT_EN
    repeat (7) begin
      step();
      chk("wd_hold", bus.o_HREADY, 3'b001);
      chk("wd_to0", bus.o_timeout, 0);
    end
    step();
    chk("wd_drop", bus.o_HREADY, 0);
    chk("wd_pulse", bus.o_timeout, 1);
    step();
    chk("wd_dead", bus.o_HREADY, 0);
    chk("wd_to1", bus.o_timeout, 0);
    step();
    chk("wd_next", bus.o_HREADY, 3'b010);
    chk("wd_next_id", bus.o_grant_id, 1);
    serve(1, 1);
`else
    repeat (110) begin
      step();
      chk("nowd_hold", bus.o_HREADY, 3'b001);
      chk("nowd_to", bus.o_timeout, 0);
    end
    serve(0, 1);
`endif

    // reset while master 2 owns
    set_trans(NS, ID, ID);
    step();
    chk("mid_own", bus.o_HREADY, 3'b100);
    set_trans(NS, NS, NS);
    HRESETn = 1'b0;
    step();
    chk("mid_rdy", bus.o_HREADY, 0);
    chk("mid_busy", bus.o_bus_busy, 0);
    chk("mid_to", bus.o_timeout, 0);
    step();
    HRESETn = 1'b1;
    step();
    chk("post_rdy", bus.o_HREADY, 3'b001);
    chk("post_id", bus.o_grant_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
